// File: rtl/slice_offset_ctrl_pkg.sv
// Shared types and helpers for the automatic slice-offset controller.
// Default widths, FSM encoding and the offset clamp.
package slice_offset_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 48;
  localparam int DEF_OUT_WIDTH  = 13;
  localparam int MAX_OFFSET     = DEF_DATA_WIDTH - DEF_OUT_WIDTH;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_ENCODE,
    ST_UPDATE
  } state_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/msb_priority_enc.sv
// Combinational highest-set-bit encoder.
// zero is high when no bit is set; idx is then 0.
module msb_priority_enc #(
  parameter int W  = 48,
  parameter int IW = 7
) (
  input  logic [W-1:0]  din,
  output logic [IW-1:0] idx,
  output logic          zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) idx = IW'(i);
    end
  end

  assign zero = ~|din;

endmodule

// File: rtl/slice_offset_ctrl.sv
// Peak-tracking offset controller for a wide-to-narrow slicer.
// Fast attack, one-step decay with hysteresis, manual override.
module slice_offset_ctrl
  import slice_offset_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int OFFSET_WIDTH = 6,
  parameter int WINDOW_LOG2  = 10,
  parameter int HEADROOM     = 1,
  parameter int HYST         = 1,
  parameter int INIT_OFFSET  = 0
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   signal_i,
  input  logic                    manual_en_i,
  input  logic [OFFSET_WIDTH-1:0] manual_offset_i,
  output logic [OFFSET_WIDTH-1:0] offset_o,
  output logic                    offset_update_o,
  output logic                    window_done_o,
  output logic [OFFSET_WIDTH:0]   peak_msb_o
);

  localparam int MaxOff = DATA_WIDTH - OUT_WIDTH;
  localparam int PW     = OFFSET_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [WINDOW_LOG2-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0]   acc_q, snap_q, mag;
  logic [PW-1:0]           enc_idx;
  logic                    enc_zero;
  logic                    win_end;
  logic [OFFSET_WIDTH-1:0] off_d;
  int                      p, tgt, cur, man;

  assign mag     = signal_i ^ {DATA_WIDTH{signal_i[DATA_WIDTH-1]}};
  assign win_end = valid_i && (cnt_q == '1);

  msb_priority_enc #(
    .W  (DATA_WIDTH),
    .IW (PW)
  ) u_enc (
    .din  (snap_q),
    .idx  (enc_idx),
    .zero (enc_zero)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (sync_reset) state_q <= ST_ACCUM;
    else            state_q <= state_d;
  end

  // FSM next state: one encode and one update cycle per window.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM:  if (win_end) state_d = ST_ENCODE;
      ST_ENCODE: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  // Window OR-accumulator; the end sample lands in the snapshot.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      snap_q <= '0;
    end else if (valid_i) begin
      cnt_q <= cnt_q + WINDOW_LOG2'(1);
      if (win_end) begin
        snap_q <= acc_q | mag;
        acc_q  <= '0;
      end else begin
        acc_q <= acc_q | mag;
      end
    end
  end

  // Peak index register and the window-complete pulse.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      peak_msb_o    <= '1;
      window_done_o <= 1'b0;
    end else begin
      window_done_o <= (state_q == ST_ENCODE);
      if (state_q == ST_ENCODE)
        peak_msb_o <= enc_zero ? '1 : enc_idx;
    end
  end

  // Next offset: manual override first, else attack/decay on update.
  always_comb begin
    off_d = offset_o;
    p     = int'($signed(peak_msb_o));
    tgt   = clamp(p + 2 + HEADROOM - OUT_WIDTH, 0, MaxOff);
    cur   = int'(offset_o);
    man   = clamp(int'(manual_offset_i), 0, MaxOff);
    if (manual_en_i) begin
      off_d = OFFSET_WIDTH'(man);
    end else if (state_q == ST_UPDATE) begin
      if (tgt > cur)
        off_d = OFFSET_WIDTH'(tgt);
      else if (tgt + HYST < cur)
        off_d = offset_o - OFFSET_WIDTH'(1);
    end
  end

  // Offset register; pulse only on a real change.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      offset_o        <= OFFSET_WIDTH'(INIT_OFFSET);
      offset_update_o <= 1'b0;
    end else begin
      offset_o        <= off_d;
      offset_update_o <= (off_d != offset_o);
    end
  end

endmodule

// File: tb/tb_slice_offset_ctrl.sv
// Bench for slice_offset_ctrl with 16-sample windows.
// Window-level reference model plus directed literal checks.
module tb_slice_offset_ctrl;

  localparam int DW  = 48;
  localparam int OW  = 13;
  localparam int OFW = 6;
  localparam int WL  = 4;
  localparam int NW  = 1 << WL;
  localparam int MX  = DW - OW;

  logic           clk = 1'b0;
  logic           sync_reset = 1'b1;
  logic           valid_i = 1'b0;
  logic [DW-1:0]  signal_i = '0;
  logic           manual_en_i = 1'b0;
  logic [OFW-1:0] manual_offset_i = '0;
  logic [OFW-1:0] offset_o;
  logic           offset_update_o;
  logic           window_done_o;
  logic [OFW:0]   peak_msb_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;
  int done_cnt = 0;
  int upd_cnt = 0;

  slice_offset_ctrl #(
    .DATA_WIDTH   (DW),
    .OUT_WIDTH    (OW),
    .OFFSET_WIDTH (OFW),
    .WINDOW_LOG2  (WL),
    .HEADROOM     (1),
    .HYST         (1),
    .INIT_OFFSET  (0)
  ) dut (
    .clk             (clk),
    .sync_reset      (sync_reset),
    .valid_i         (valid_i),
    .signal_i        (signal_i),
    .manual_en_i     (manual_en_i),
    .manual_offset_i (manual_offset_i),
    .offset_o        (offset_o),
    .offset_update_o (offset_update_o),
    .window_done_o   (window_done_o),
    .peak_msb_o      (peak_msb_o)
  );

  always #5 clk = ~clk;

  function automatic int msb_of(input logic [DW-1:0] x);
    int r;
    r = -1;
    for (int i = 0; i < DW; i++) if (x[i]) r = i;
    return r;
  endfunction

  function automatic int target_of(input int p);
    int t;
    t = p + 2 + 1 - OW;
    if (t < 0) t = 0;
    if (t > MX) t = MX;
    return t;
  endfunction

  // Reference model: window-level view of the expected outputs.
  int            cyc = 0;
  int            m_off = 0;
  bit            m_upd = 1'b0;
  bit            m_done = 1'b0;
  logic [OFW:0]  m_peak = '1;
  int            m_n = 0;
  logic [DW-1:0] m_max = '0;
  int            ev_e[$];
  int            ev_p[$];

  always @(posedge clk) begin
    int nxt, t;
    logic [DW-1:0] mg;
    cyc++;
    if (sync_reset) begin
      m_off = 0; m_upd = 0; m_done = 0; m_peak = '1;
      m_n = 0; m_max = '0;
      ev_e.delete(); ev_p.delete();
    end else begin
      nxt = m_off;
      m_done = 0;
      foreach (ev_e[k]) begin
        if (ev_e[k] == cyc - 1) begin
          m_done = 1;
          m_peak = (ev_p[k] < 0) ? '1 : (OFW+1)'(ev_p[k]);
        end
        if (ev_e[k] == cyc - 2 && !manual_en_i) begin
          t = target_of(ev_p[k]);
          if (t > m_off) nxt = t;
          else if (t + 1 < m_off) nxt = m_off - 1;
        end
      end
      if (manual_en_i)
        nxt = (int'(manual_offset_i) > MX) ? MX : int'(manual_offset_i);
      m_upd = (nxt != m_off);
      m_off = nxt;
      while (ev_e.size() > 0 && ev_e[0] < cyc - 2) begin
        void'(ev_e.pop_front());
        void'(ev_p.pop_front());
      end
      if (valid_i) begin
        mg = signal_i[DW-1] ? ~signal_i : signal_i;
        if (mg > m_max) m_max = mg;
        m_n++;
        if (m_n == NW) begin
          ev_e.push_back(cyc);
          ev_p.push_back(msb_of(m_max));
          m_n = 0;
          m_max = '0;
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      n_checks += 4;
      if (int'(offset_o) != m_off) begin
        n_errors++;
        $display("FAIL offset_o cyc=%0d got=%0d exp=%0d", cyc, offset_o, m_off);
      end
      if (offset_update_o != m_upd) begin
        n_errors++;
        $display("FAIL offset_update_o cyc=%0d got=%0b exp=%0b", cyc, offset_update_o, m_upd);
      end
      if (window_done_o != m_done) begin
        n_errors++;
        $display("FAIL window_done_o cyc=%0d got=%0b exp=%0b", cyc, window_done_o, m_done);
      end
      if (peak_msb_o != m_peak) begin
        n_errors++;
        $display("FAIL peak_msb_o cyc=%0d got=%0h exp=%0h", cyc, peak_msb_o, m_peak);
      end
      if (window_done_o) done_cnt++;
      if (offset_update_o) upd_cnt++;
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [DW-1:0] s, input logic v,
                       input logic me, input logic [OFW-1:0] mo,
                       input logic rst);
    @(negedge clk);
    signal_i = s;
    valid_i = v;
    manual_en_i = me;
    manual_offset_i = mo;
    sync_reset = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic window(input logic [DW-1:0] pk);
    drive(pk, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i < NW; i++) drive('0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b0, '0, 1'b1);
    drive('0, 1'b0, 1'b0, '0, 1'b1);
    drive('0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int d0, u0;
    logic [63:0] r;
    logic [DW-1:0] s;
    logic me;
    logic [OFW-1:0] mo;

    drive('0, 1'b0, 1'b0, '0, 1'b1);
    drive('0, 1'b0, 1'b0, '0, 1'b1);
    chk_on = 1'b1;
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    lit("reset_offset", int'(offset_o), 0);
    lit("reset_peak", int'(peak_msb_o), 127);
    lit("reset_done", int'(window_done_o), 0);

    d0 = done_cnt; u0 = upd_cnt;
    for (int i = 0; i < 3 * NW; i++) drive('0, 1'b1, 1'b0, '0, 1'b0);
    idle(4);
    lit("zero_windows", done_cnt - d0, 3);
    lit("zero_updates", upd_cnt - u0, 0);
    lit("zero_offset", int'(offset_o), 0);
    lit("zero_peak", int'(peak_msb_o), 127);

    window(48'h1 << 20);
    idle(4);
    lit("attack_offset", int'(offset_o), 10);
    lit("attack_peak", int'(peak_msb_o), 20);

    for (int w = 0; w < 5; w++) begin
      window(48'h1 << 15);
      idle(3);
      lit("decay_offset", int'(offset_o), (w < 4) ? 9 - w : 6);
    end

    window(48'h8000_0000_0000);
    idle(4);
    lit("clamp_offset", int'(offset_o), 35);
    lit("clamp_peak", int'(peak_msb_o), 46);

    do_reset();
    drive(48'h1 << 20, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i < NW; i++) begin
      drive('0, 1'b0, 1'b0, '0, 1'b0);
      drive('0, 1'b1, 1'b0, '0, 1'b0);
    end
    idle(4);
    lit("gap_offset", int'(offset_o), 10);

    drive('0, 1'b0, 1'b1, 6'd40, 1'b0);
    drive('0, 1'b0, 1'b1, 6'd40, 1'b0);
    lit("manual_offset", int'(offset_o), 35);
    window('0);
    idle(4);
    lit("release_decay", int'(offset_o), 34);

    for (int i = 0; i < 10; i++)
      drive((i == 3) ? (48'h1 << 30) : '0, 1'b1, 1'b0, '0, 1'b0);
    drive('0, 1'b0, 1'b0, '0, 1'b1);
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    lit("midreset_offset", int'(offset_o), 0);
    u0 = upd_cnt;
    window('0);
    idle(4);
    lit("midreset_updates", upd_cnt - u0, 0);
    lit("midreset_peak", int'(peak_msb_o), 127);

    me = 1'b0; mo = '0;
    for (int i = 0; i < 1500; i++) begin
      r = {$urandom, $urandom};
      s = r[DW-1:0] >> $urandom_range(0, DW - 1);
      if ($urandom_range(0, 1) == 1) s = -s;
      if ($urandom_range(0, 40) == 0) me = ~me;
      if ($urandom_range(0, 10) == 0) mo = OFW'($urandom_range(0, 63));
      drive(s, $urandom_range(0, 3) != 0, me, mo,
            $urandom_range(0, 400) == 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slice_offset_ctrl.md
Name: slice_offset_ctrl

Overview:
Automatic slice-offset controller that drives the slice_offset_i input of a slicer_<DATA_WIDTH>_<OUT_WIDTH> instance. It watches the same wide signed stream that feeds the slicer and measures the peak magnitude over fixed windows of valid samples. From that peak it picks the offset that places the peak inside OUT_WIDTH bits with headroom: fast attack, slow decay with hysteresis. A manual override path supports bring-up and calibration.

Parameters:
DATA_WIDTH, 48, width of signed input stream (matches slicer input)
OUT_WIDTH, 13, slicer output width
OFFSET_WIDTH, 6, offset port width; must hold DATA_WIDTH-OUT_WIDTH (35)
WINDOW_LOG2, 10, window length = 2^WINDOW_LOG2 valid samples
HEADROOM, 1, extra bits kept above the peak
HYST, 1, decay hysteresis in offset steps
INIT_OFFSET, 0, offset_o value after reset

Ports:
clk  in  1  clock
sync_reset  in  1  synchronous active-high reset
valid_i  in  1  input sample valid
signal_i  in  DATA_WIDTH  signed two's-complement sample
manual_en_i  in  1  1 = offset_o follows manual_offset_i
manual_offset_i  in  OFFSET_WIDTH  manual offset value
offset_o  out  OFFSET_WIDTH  offset to slicer
offset_update_o  out  1  one-cycle pulse when offset_o changes
window_done_o  out  1  one-cycle pulse per completed window
peak_msb_o  out  OFFSET_WIDTH+1  MSB index of last window peak; all-ones if peak = 0

Behaviour:
- Reset: offset_o=INIT_OFFSET, offset_update_o=0, window_done_o=0, peak_msb_o=all-ones, sample count=0, OR-accumulator=0, state=ACCUM.
- Reset asserted mid-window discards the partial window. The first window after release starts at the first valid_i.
- Magnitude per sample: mag = signal_i XOR {DATA_WIDTH{signal_i[MSB]}} (one's-complement abs, cannot overflow).
- Accumulator: acc |= mag on each valid_i. Counter increments on valid_i. Cycles with valid_i=0 are ignored.
- Window end is the valid_i cycle where count = 2^WINDOW_LOG2-1. On that cycle: snapshot = acc|mag, acc cleared, count wraps to 0, state moves to ENCODE.
- Samples in ENCODE/UPDATE cycles belong to the new window. No samples are lost.
- FSM states:
  - ACCUM: normal accumulation; exits on window end.
  - ENCODE (1 cycle): priority-encode snapshot to p (highest set bit; -1 if zero); register peak_msb_o.
  - UPDATE (1 cycle): decide and apply; return to ACCUM.
- Decision arithmetic:
  - need = p+2+HEADROOM (signed bits).
  - target = need-OUT_WIDTH, clamped to [0, DATA_WIDTH-OUT_WIDTH]. Compute signed with enough width for p=-1.
- Auto rule, when manual_en_i=0:
  - target > offset_o: offset_o <= target (attack).
  - target+HYST < offset_o: offset_o <= offset_o-1 (decay, one step per window).
  - otherwise hold.
- Latency: offset_o and offset_update_o change on the 2nd clock edge after the window-end sample edge. window_done_o pulses in the UPDATE cycle.
- offset_update_o pulses only if the offset value actually changes.
- Manual: while manual_en_i=1, offset_o <= min(manual_offset_i, DATA_WIDTH-OUT_WIDTH), registered with 1-cycle latency. offset_update_o pulses on each change.
  - Windows and peak_msb_o keep running while manual is active; the auto decision is discarded.
  - On deassert, the auto rule resumes from the current offset_o.
- If manual_en_i and an UPDATE coincide, manual wins.
- offset_o never exceeds DATA_WIDTH-OUT_WIDTH.

Decomposition:
- Shared package holds:
  - FSM state enum (ACCUM, ENCODE, UPDATE).
  - Localparam MAX_OFFSET = DATA_WIDTH-OUT_WIDTH.
  - A clamp function.
- One sub-module: msb_priority_enc (DATA_WIDTH in, index + zero flag out, combinational), reusable by other energy-detect blocks.

Test Plan:
Bench config: defaults, WINDOW_LOG2=4 (16-sample windows).
- All-zero samples, 48 valid -> window_done_o at 3 windows, peak_msb_o=all-ones, offset_o stays 0, no offset_update_o.
- One sample 2^20 in window of zeros -> p=20, target=10; offset_o=10 and offset_update_o pulse 2 cycles after the 16th valid.
- Then windows peaking at 2^15 (target 5) -> offset_o steps 9,8,7,6 over four windows, then holds at 6.
- Single sample -2^47 (48'h8000_0000_0000) -> p=46, target clamped to 35; offset_o=35.
- Valid gaps (valid_i toggled 1/0) with peak 2^20 -> window completes after exactly 16 valid samples; same result as case 2.
- manual_en_i=1, manual_offset_i=40 -> offset_o=35 one cycle later.
- Release manual with zero input, then one more window -> decay to 34.
- sync_reset after 10 samples of a window holding 2^30 -> offset_o=INIT_OFFSET. Next window of zeros yields no update; the partial window has no effect.
